// File: rtl/ltl_event_logger.sv
// ltl_event_logger: timestamps non-zero LTL property flag vectors and queues them for a
// valid/ready reporting path. It also keeps sticky flags, saturating per-property hit
// counters and a saturating drop counter for software readout.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   run        monitor enable; gates timestamp, capture and statistics
//   hits       per-property result flags from the cluster
//   clear      synchronous clear of sticky, hit counters, drop counter and pending overflow
//   evt_valid  FIFO head record available
//   evt_ready  consumer accepts the head record
//   evt_ts     timestamp of the head record (0 when empty)
//   evt_hits   flag vector of the head record (0 when empty)
//   evt_ovf    records were dropped immediately before the head record (0 when empty)
//   sticky     OR of all hits since the last reset or clear
//   cnt_sel    hit counter index for readout
//   cnt_val    selected hit counter (0 for an out-of-range index)
//   drop_cnt   saturating count of dropped records
module ltl_event_logger #(
  parameter int unsigned NUM_PROPS = 9,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [NUM_PROPS-1:0] hits,
  input  logic                 clear,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [TS_W-1:0]      evt_ts,
  output logic [NUM_PROPS-1:0] evt_hits,
  output logic                 evt_ovf,
  output logic [NUM_PROPS-1:0] sticky,
  input  logic [3:0]           cnt_sel,
  output logic [CNT_W-1:0]     cnt_val,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  // Record storage; only the occupancy/pointers need reset since empty heads read as 0.
  logic [TS_W-1:0]      ts_mem_q   [DEPTH];
  logic [NUM_PROPS-1:0] hits_mem_q [DEPTH];
  logic                 ovf_mem_q  [DEPTH];

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic [TS_W-1:0]      ts_q;
  logic                 pend_ovf_q;
  logic [NUM_PROPS-1:0] sticky_q;
  logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
  logic [CNT_W-1:0]     drop_q;

  logic capture, full, pop, push, drop;

  assign capture = run && (hits != '0);
  assign full    = (count_q == FullCnt);
  assign pop     = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem_q[wr_ptr_q]   <= ts_q;
      hits_mem_q[wr_ptr_q] <= hits;
      ovf_mem_q[wr_ptr_q]  <= pend_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_ovf_q <= 1'b0;
      sticky_q   <= '0;
      drop_q     <= '0;
      for (int i = 0; i < NUM_PROPS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (run) begin
        ts_q <= ts_q + TS_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end

      // Clear wins over any same-cycle statistics update.
      if (clear) begin
        sticky_q   <= '0;
        drop_q     <= '0;
        pend_ovf_q <= 1'b0;
        for (int i = 0; i < NUM_PROPS; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        if (run) begin
          sticky_q <= sticky_q | hits;
        end
        if (drop && (drop_q != '1)) begin
          drop_q <= drop_q + CNT_W'(1);
        end
        if (drop) begin
          pend_ovf_q <= 1'b1;
        end else if (push) begin
          pend_ovf_q <= 1'b0;
        end
        for (int i = 0; i < NUM_PROPS; i++) begin
          if (run && hits[i] && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_ts    = evt_valid ? ts_mem_q[rd_ptr_q]   : '0;
  assign evt_hits  = evt_valid ? hits_mem_q[rd_ptr_q] : '0;
  assign evt_ovf   = evt_valid ? ovf_mem_q[rd_ptr_q]  : 1'b0;
  assign sticky    = sticky_q;
  assign drop_cnt  = drop_q;

  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < NUM_PROPS; i++) begin
      if (cnt_sel == 4'(i)) begin
        cnt_val = cnt_q[i];
      end
    end
  end

endmodule
